ines_loader: RTL and testbench



---
 rtl/ines_pkg.sv | 46 ++++
 rtl/ines_header_decode.sv | 53 +++++
 rtl/ines_loader.sv | 161 ++++++++++++++++
 tb/tb_ines_loader.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/ines_pkg.sv
// Shared types, codes and helpers for the iNES / NES 2.0 game loader.
package ines_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_HDR  = 3'd0;
  localparam state_t ST_TRN  = 3'd1;
  localparam state_t ST_PRG  = 3'd2;
  localparam state_t ST_CHR  = 3'd3;
  localparam state_t ST_CLR0 = 3'd4;
  localparam state_t ST_CLR1 = 3'd5;
  localparam state_t ST_DONE = 3'd6;
  localparam state_t ST_ERR  = 3'd7;

  localparam logic [2:0] ERR_NONE     = 3'd0;
  localparam logic [2:0] ERR_MAGIC    = 3'd1;
  localparam logic [2:0] ERR_EXPSIZE  = 3'd2;
  localparam logic [2:0] ERR_OVERSIZE = 3'd3;
  localparam logic [2:0] ERR_NOPRG    = 3'd4;

  localparam int MF_MAPPER_LSB    = 0;
  localparam int MF_PRG_BKT_LSB   = 8;
  localparam int MF_CHR_BKT_LSB   = 11;
  localparam int MF_MIRROR        = 14;
  localparam int MF_CHR_RAM       = 15;
  localparam int MF_FOUR_SCREEN   = 16;
  localparam int MF_BATTERY       = 17;
  localparam int MF_NES2          = 18;
  localparam int MF_MAPPER_HI_LSB = 19;

  // 12-bit unit counts; 4095 PRG units x 16 KB still fits the 26-bit counter.
  localparam int UNITS_W = 12;
  localparam int CNT_W   = 26;

  function automatic logic [2:0] size_bucket(input logic [UNITS_W-1:0] units);
    if      (units <= 12'd1)  return 3'd0;
    else if (units <= 12'd2)  return 3'd1;
    else if (units <= 12'd4)  return 3'd2;
    else if (units <= 12'd8)  return 3'd3;
    else if (units <= 12'd16) return 3'd4;
    else if (units <= 12'd32) return 3'd5;
    else if (units <= 12'd64) return 3'd6;
    else                      return 3'd7;
  endfunction

endpackage

// File: rtl/ines_header_decode.sv
// Combinational decode of header bytes 0..9 into unit counts, flags and an
// abort code. Bytes 10..15 carry nothing the loader uses.
module ines_header_decode
  import ines_pkg::*;
#(
  parameter int unsigned PRG_MAX = 64,
  parameter int unsigned CHR_MAX = 128
) (
  input  logic [9:0][7:0]       i_hdr,
  output logic [UNITS_W-1:0]    o_prg_units,
  output logic [UNITS_W-1:0]    o_chr_units,
  output logic                  o_trainer,
  output logic [31:0]           o_mapper_flags,
  output logic [2:0]            o_err_code
);

  logic w_nes2;
  logic w_unused;

  assign w_nes2      = (i_hdr[7][3:2] == 2'b10);
  assign o_prg_units = w_nes2 ? {i_hdr[9][3:0], i_hdr[4]} : {4'd0, i_hdr[4]};
  assign o_chr_units = w_nes2 ? {i_hdr[9][7:4], i_hdr[5]} : {4'd0, i_hdr[5]};
  assign o_trainer   = i_hdr[6][2];
  assign w_unused    = ^{i_hdr[8][7:4], i_hdr[7][1:0]};

  // Abort reasons in priority order.
  always_comb begin
    if (i_hdr[0] != 8'h4E || i_hdr[1] != 8'h45 || i_hdr[2] != 8'h53 || i_hdr[3] != 8'h1A)
      o_err_code = ERR_MAGIC;
    else if (w_nes2 && (i_hdr[9][3:0] == 4'hF || i_hdr[9][7:4] == 4'hF))
      o_err_code = ERR_EXPSIZE;
    else if (32'(o_prg_units) > PRG_MAX || 32'(o_chr_units) > CHR_MAX)
      o_err_code = ERR_OVERSIZE;
    else if (o_prg_units == 12'd0)
      o_err_code = ERR_NOPRG;
    else
      o_err_code = ERR_NONE;
  end

  always_comb begin
    o_mapper_flags = 32'd0;
    o_mapper_flags[MF_MAPPER_LSB +: 8]    = {i_hdr[7][7:4], i_hdr[6][7:4]};
    o_mapper_flags[MF_PRG_BKT_LSB +: 3]   = size_bucket(o_prg_units);
    o_mapper_flags[MF_CHR_BKT_LSB +: 3]   = size_bucket(o_chr_units);
    o_mapper_flags[MF_MIRROR]             = i_hdr[6][0];
    o_mapper_flags[MF_CHR_RAM]            = (o_chr_units == 12'd0);
    o_mapper_flags[MF_FOUR_SCREEN]        = i_hdr[6][3];
    o_mapper_flags[MF_BATTERY]            = i_hdr[6][1];
    o_mapper_flags[MF_NES2]               = w_nes2;
    o_mapper_flags[MF_MAPPER_HI_LSB +: 4] = w_nes2 ? i_hdr[8][3:0] : 4'd0;
  end

endmodule

// File: rtl/ines_loader.sv
// Streams an iNES / NES 2.0 image into NES memory (trainer, PRG, CHR), then
// zero-fills two RAM regions and raises done to release the core.
module ines_loader
  import ines_pkg::*;
#(
  parameter int unsigned ADDR_W       = 22,
  parameter int unsigned PRG_BASE     = 32'h00_0000,
  parameter int unsigned CHR_BASE     = 32'h20_0000,
  parameter int unsigned TRAINER_BASE = 32'h3C_1000,
  parameter int unsigned CLR0_BASE    = 32'h38_0000,
  parameter int unsigned CLR0_LEN     = 2048,
  parameter int unsigned CLR1_BASE    = 32'h30_0000,
  parameter int unsigned CLR1_LEN     = 2048,
  parameter int unsigned PRG_MAX      = 64,
  parameter int unsigned CHR_MAX      = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data,
  output logic              mem_write,
  output logic [31:0]       mapper_flags,
  output logic              done,
  output logic              error,
  output logic [2:0]        err_code
);

  state_t              r_state;
  logic [9:0][7:0]     r_hdr;
  logic [3:0]          r_hdr_idx;
  logic [ADDR_W-1:0]   r_addr;
  logic [CNT_W-1:0]    r_cnt;
  logic [UNITS_W-1:0]  r_prg_units;
  logic [UNITS_W-1:0]  r_chr_units;
  logic [31:0]         r_mapper_flags;
  logic [2:0]          r_err_code;

  logic [UNITS_W-1:0]  w_dec_prg;
  logic [UNITS_W-1:0]  w_dec_chr;
  logic                w_dec_trainer;
  logic [31:0]         w_dec_flags;
  logic [2:0]          w_dec_err;

  state_t              w_chr_state, w_clr0_state, w_clr1_state;
  logic [ADDR_W-1:0]   w_chr_addr, w_clr0_addr, w_clr1_addr;
  logic [CNT_W-1:0]    w_chr_cnt, w_clr0_cnt, w_clr1_cnt;

  ines_header_decode #(.PRG_MAX(PRG_MAX), .CHR_MAX(CHR_MAX)) u_decode (
    .i_hdr          (r_hdr),
    .o_prg_units    (w_dec_prg),
    .o_chr_units    (w_dec_chr),
    .o_trainer      (w_dec_trainer),
    .o_mapper_flags (w_dec_flags),
    .o_err_code     (w_dec_err)
  );

  // Entry point of each later segment; empty segments fall through to the next.
  always_comb begin
    if (CLR1_LEN != 32'd0) begin
      w_clr1_state = ST_CLR1; w_clr1_addr = ADDR_W'(CLR1_BASE); w_clr1_cnt = CNT_W'(CLR1_LEN);
    end else begin
      w_clr1_state = ST_DONE; w_clr1_addr = r_addr;             w_clr1_cnt = '0;
    end
    if (CLR0_LEN != 32'd0) begin
      w_clr0_state = ST_CLR0; w_clr0_addr = ADDR_W'(CLR0_BASE); w_clr0_cnt = CNT_W'(CLR0_LEN);
    end else begin
      w_clr0_state = w_clr1_state; w_clr0_addr = w_clr1_addr; w_clr0_cnt = w_clr1_cnt;
    end
    if (r_chr_units != 12'd0) begin
      w_chr_state = ST_CHR; w_chr_addr = ADDR_W'(CHR_BASE); w_chr_cnt = {1'b0, r_chr_units, 13'd0};
    end else begin
      w_chr_state = w_clr0_state; w_chr_addr = w_clr0_addr; w_chr_cnt = w_clr0_cnt;
    end
  end

  always_comb begin
    in_ready  = 1'b0;
    mem_write = 1'b0;
    mem_data  = 8'd0;
    case (r_state)
      ST_HDR, ST_ERR: in_ready = 1'b1;
      ST_TRN, ST_PRG, ST_CHR: begin
        in_ready  = mem_ready;
        mem_write = in_valid & mem_ready;
        mem_data  = in_data;
      end
      ST_CLR0, ST_CLR1: mem_write = mem_ready;
      default: in_ready = 1'b0;
    endcase
  end

  // Only bytes 0..9 carry decoded fields.
  always_ff @(posedge clk) begin
    if (r_state == ST_HDR && in_valid && r_hdr_idx < 4'd10)
      r_hdr[r_hdr_idx] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= ST_HDR;
      r_hdr_idx      <= 4'd0;
      r_addr         <= '0;
      r_cnt          <= '0;
      r_prg_units    <= '0;
      r_chr_units    <= '0;
      r_mapper_flags <= 32'd0;
      r_err_code     <= ERR_NONE;
    end else begin
      case (r_state)
        ST_HDR: begin
          if (in_valid) begin
            r_hdr_idx <= r_hdr_idx + 4'd1;
            if (r_hdr_idx == 4'd15) begin
              r_mapper_flags <= w_dec_flags;
              r_err_code     <= w_dec_err;
              r_prg_units    <= w_dec_prg;
              r_chr_units    <= w_dec_chr;
              if (w_dec_err != ERR_NONE) begin
                r_state <= ST_ERR;
              end else if (w_dec_trainer) begin
                r_state <= ST_TRN; r_addr <= ADDR_W'(TRAINER_BASE); r_cnt <= CNT_W'(512);
              end else begin
                r_state <= ST_PRG; r_addr <= ADDR_W'(PRG_BASE); r_cnt <= {w_dec_prg, 14'd0};
              end
            end
          end
        end
        ST_TRN, ST_PRG, ST_CHR, ST_CLR0, ST_CLR1: begin
          if (mem_write) begin
            if (r_cnt == CNT_W'(1)) begin
              case (r_state)
                ST_TRN: begin
                  r_state <= ST_PRG; r_addr <= ADDR_W'(PRG_BASE); r_cnt <= {r_prg_units, 14'd0};
                end
                ST_PRG:  begin r_state <= w_chr_state;  r_addr <= w_chr_addr;  r_cnt <= w_chr_cnt;  end
                ST_CHR:  begin r_state <= w_clr0_state; r_addr <= w_clr0_addr; r_cnt <= w_clr0_cnt; end
                ST_CLR0: begin r_state <= w_clr1_state; r_addr <= w_clr1_addr; r_cnt <= w_clr1_cnt; end
                default: r_state <= ST_DONE;
              endcase
            end else begin
              r_addr <= r_addr + ADDR_W'(1);
              r_cnt  <= r_cnt - CNT_W'(1);
            end
          end
        end
        default: r_state <= r_state;
      endcase
    end
  end

  assign mem_addr     = r_addr;
  assign mapper_flags = r_mapper_flags;
  assign err_code     = r_err_code;
  assign done         = (r_state == ST_DONE);
  assign error        = (r_state == ST_ERR);

endmodule

// File: tb/tb_ines_loader.sv
// Directed bench for ines_loader: header decode table, full loads with write
// address/data tracking, back-pressure, error drain and reset mid-load.
module tb_ines_loader;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, mem_ready, mem_write, done, error;
  logic [7:0]  in_data, mem_data;
  logic [21:0] mem_addr;
  logic [31:0] mapper_flags;
  logic [2:0]  err_code;

  always #5 clk = ~clk;

  ines_loader dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_write(mem_write), .mapper_flags(mapper_flags),
    .done(done), .error(error), .err_code(err_code)
  );

  typedef struct {
    logic [15:0][7:0] hdr;
    logic [31:0]      flags;
    logic [2:0]       err;
    logic [21:0]      addr;
    bit               full;
    bit               bp;
    bit               trn;
    int               prg;
    int               chr;
  } vec_t;

  vec_t vec[10];

  int checks = 0;
  int errors = 0;
  logic [15:0][7:0] hdr_bytes;
  int in_pos, wr_idx, wr_bad, bad_idx;
  logic [21:0] bad_addr;
  logic [7:0]  bad_data;
  bit cfg_none, cfg_trn, bp_en;
  int cfg_prg, cfg_chr;

  function automatic logic [7:0] pat(input int p);
    return 8'(p * 13 + (p >> 8));
  endfunction

  function automatic logic [15:0][7:0] mk(input logic [7:0] b4, b5, b6, b7, b8, b9);
    logic [15:0][7:0] h;
    h = '0;
    h[0] = 8'h4E; h[1] = 8'h45; h[2] = 8'h53; h[3] = 8'h1A;
    h[4] = b4; h[5] = b5; h[6] = b6; h[7] = b7; h[8] = b8; h[9] = b9;
    return h;
  endfunction

  function automatic int total_writes();
    if (cfg_none) return 0;
    return (cfg_trn ? 512 : 0) + cfg_prg + cfg_chr + 4096;
  endfunction

  // Expected address/data of the w-th write of a load.
  function automatic void exp_wr(input int w, output logic [21:0] a, output logic [7:0] d, output bit ok);
    int off;
    int t;
    off = w; t = cfg_trn ? 512 : 0; ok = 1'b1; d = pat(w); a = 22'd0;
    if (cfg_none) ok = 1'b0;
    else if (off < t) a = 22'h3C1000 + 22'(off);
    else begin
      off -= t;
      if (off < cfg_prg) a = 22'(off);
      else begin
        off -= cfg_prg;
        if (off < cfg_chr) a = 22'h200000 + 22'(off);
        else begin
          off -= cfg_chr; d = 8'h00;
          if (off < 2048) a = 22'h380000 + 22'(off);
          else if (off < 4096) a = 22'h300000 + 22'(off - 2048);
          else ok = 1'b0;
        end
      end
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
    end
  endtask

  task automatic drive_inputs();
    if (in_pos < 16) in_data = hdr_bytes[in_pos[3:0]];
    else             in_data = pat(in_pos - 16);
    mem_ready = bp_en ? ($urandom_range(3, 0) != 32'd0) : 1'b1;
  endtask

  // One clock: observe write strobe at negedge, drive next inputs #1 after posedge.
  task automatic cycle();
    logic [21:0] ea;
    logic [7:0]  ed;
    bit ok, acc;
    @(negedge clk);
    acc = in_valid && in_ready;
    if (mem_write) begin
      exp_wr(wr_idx, ea, ed, ok);
      if (!ok || !mem_ready || mem_addr !== ea || mem_data !== ed) begin
        if (wr_bad == 0) begin bad_idx = wr_idx; bad_addr = mem_addr; bad_data = mem_data; end
        wr_bad++;
      end
      wr_idx++;
    end
    @(posedge clk); #1;
    if (acc) in_pos++;
    drive_inputs();
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0; in_valid = 1'b1;
    in_pos = 0; wr_idx = 0; wr_bad = 0;
    drive_inputs();
  endtask

  task automatic send_header();
    int n;
    n = 0;
    while (in_pos < 16 && n < 64) begin cycle(); n++; end
    chk("hdr_accepted", 32'(in_pos), 32'd16);
  endtask

  task automatic run_load(input int t, input bit exact, input int budget);
    int n;
    n = 0;
    while (done !== 1'b1 && n < budget) begin cycle(); n++; end
    chk("done", 32'(done), 32'd1);
    if (exact) chk("load_cycles", 32'(n), 32'(t));
    chk("write_count", 32'(wr_idx), 32'(t));
    chk("bytes_consumed", 32'(in_pos - 16), 32'(t - 4096));
    chk("ready_in_done", 32'(in_ready), 32'd0);
    repeat (4) cycle();
    chk("done_held", 32'(done), 32'd1);
    chk("writes_ok", 32'(wr_bad), 32'd0);
    if (wr_bad != 0)
      $display("  first bad write #%0d addr 'h%0h data 'h%0h", bad_idx, bad_addr, bad_data);
  endtask

  task automatic set_vec(input int i, input logic [15:0][7:0] h, input logic [31:0] f,
                         input logic [2:0] e, input logic [21:0] a, input bit full,
                         input bit bp, input bit trn, input int prg, input int chr);
    vec[i].hdr = h; vec[i].flags = f; vec[i].err = e; vec[i].addr = a;
    vec[i].full = full; vec[i].bp = bp; vec[i].trn = trn; vec[i].prg = prg; vec[i].chr = chr;
  endtask

  initial begin
    logic [15:0][7:0] h;
    int n;
    reset = 1'b1; in_valid = 1'b0; in_data = 8'd0; mem_ready = 1'b1;
    bp_en = 1'b0; cfg_none = 1'b0; cfg_trn = 1'b0; cfg_prg = 32768; cfg_chr = 8192;
    in_pos = 0; wr_idx = 0; wr_bad = 0; bad_idx = 0; bad_addr = '0; bad_data = '0;

    set_vec(0, mk(8'h02, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00), 32'h0000_4100, 3'd0, 22'h000000, 1, 0, 0, 32768, 8192);
    h = mk(8'h02, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00); h[0] = 8'h4F;
    set_vec(1, h,                                           32'h0,         3'd1, 22'h0,      0, 0, 0, 0, 0);
    set_vec(2, mk(8'h01, 8'h00, 8'h00, 8'h08, 8'h01, 8'h00), 32'h000C_8000, 3'd0, 22'h000000, 0, 0, 0, 0, 0);
    set_vec(3, mk(8'h01, 8'h00, 8'h00, 8'h08, 8'h01, 8'h0F), 32'h0,         3'd2, 22'h0,      0, 0, 0, 0, 0);
    set_vec(4, mk(8'h41, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00), 32'h0,         3'd3, 22'h0,      0, 0, 0, 0, 0);
    set_vec(5, mk(8'h01, 8'h81, 8'h00, 8'h00, 8'h00, 8'h00), 32'h0,         3'd3, 22'h0,      0, 0, 0, 0, 0);
    set_vec(6, mk(8'h00, 8'h00, 8'h00, 8'h08, 8'h00, 8'h01), 32'h0,         3'd3, 22'h0,      0, 0, 0, 0, 0);
    set_vec(7, mk(8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00), 32'h0,         3'd4, 22'h0,      0, 0, 0, 0, 0);
    set_vec(8, mk(8'h40, 8'h80, 8'hAB, 8'h50, 8'h07, 8'h00), 32'h0003_7E5A, 3'd0, 22'h000000, 0, 0, 0, 0, 0);
    set_vec(9, mk(8'h01, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00), 32'h0000_8000, 3'd0, 22'h3C1000, 1, 1, 1, 16384, 0);

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_mem_write", 32'(mem_write), 32'd0);
    chk("rst_mem_data", 32'(mem_data), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_err_code", 32'(err_code), 32'd0);
    chk("rst_mapper_flags", mapper_flags, 32'd0);

    // Reset after 100 PRG bytes.
    hdr_bytes = vec[0].hdr; cfg_none = 1'b0; cfg_trn = 1'b0; cfg_prg = 32768; cfg_chr = 8192;
    do_reset();
    send_header();
    n = 0;
    while (wr_idx < 100 && n < 300) begin cycle(); n++; end
    chk("mid_writes", 32'(wr_idx), 32'd100);
    chk("mid_writes_ok", 32'(wr_bad), 32'd0);
    chk("mid_addr", 32'(mem_addr), 32'd100);
    chk("mid_flags", mapper_flags, 32'h0000_4100);
    do_reset();
    chk("mr_flags", mapper_flags, 32'd0);
    chk("mr_done", 32'(done), 32'd0);
    chk("mr_error", 32'(error), 32'd0);
    chk("mr_in_ready", 32'(in_ready), 32'd1);
    chk("mr_mem_addr", 32'(mem_addr), 32'd0);
    chk("mr_mem_write", 32'(mem_write), 32'd0);

    for (int i = 0; i < 10; i++) begin
      hdr_bytes = vec[i].hdr;
      bp_en     = vec[i].bp;
      cfg_none  = (vec[i].err != 3'd0);
      cfg_trn   = vec[i].trn;
      cfg_prg   = vec[i].prg;
      cfg_chr   = vec[i].chr;
      do_reset();
      send_header();
      chk($sformatf("v%0d_err_code", i), 32'(err_code), 32'(vec[i].err));
      if (vec[i].err == 3'd0) begin
        chk($sformatf("v%0d_flags", i), mapper_flags, vec[i].flags);
        chk($sformatf("v%0d_error", i), 32'(error), 32'd0);
        chk($sformatf("v%0d_base_addr", i), 32'(mem_addr), 32'(vec[i].addr));
        if (vec[i].full) run_load(total_writes(), !vec[i].bp, 60000);
      end else begin
        chk($sformatf("v%0d_error", i), 32'(error), 32'd1);
        chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'd1);
        repeat (8) cycle();
        chk($sformatf("v%0d_drained", i), 32'(in_pos), 32'd24);
        chk($sformatf("v%0d_no_writes", i), 32'(wr_idx), 32'd0);
        chk($sformatf("v%0d_error_held", i), 32'(error), 32'd1);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
